seq_mult_core: RTL

SEQ_MULT_CORE -- requirements
Module: seq_mult_core

---
 rtl/seq_mult_core.sv | 82 ++++++++
 1 files changed

// File: rtl/seq_mult_core.sv
// Sequential shift-and-add multiplier with a valid/ready handshake on both sides.
// It handles signed operands by multiplying their magnitudes and then negating the result.
module seq_mult_core #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state, state_nxt;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [2*WIDTH-1:0]   acc;
  logic                 neg;

  // -2^(WIDTH-1) negates to itself and reads correctly as the unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sm);
    magnitude = (sm && v[WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] v, input logic n);
    apply_sign = n ? (~v + 1'b1) : v;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid)     state_nxt = CALC;
      CALC: if (mplier == '0) state_nxt = DONE;
      DONE: if (out_ready)    state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          mcand  <= {{WIDTH{1'b0}}, magnitude(a, signed_mode)};
          mplier <= magnitude(b, signed_mode);
          acc    <= '0;
          neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
        end
        CALC: if (mplier != '0) begin
          acc    <= acc + (mplier[0] ? mcand : '0);
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
        end else begin
          product <= apply_sign(acc, neg);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule
